// File: rtl/bcd_display_driver_if.sv
// Handshake/display bundle between the result producer and the BCD display driver.
// The producer drives load/q_in; the driver returns status and the pin-level display signals.
interface bcd_display_driver_if;
    logic       load;
    logic [9:0] q_in;
    logic       busy;
    logic       done;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output load, q_in,
        input  busy, done, an, seg, dp
    );

    modport slave (
        input  load, q_in,
        output busy, done, an, seg, dp
    );
endinterface

// File: rtl/bcd_display_driver.sv
// Captures a 10-bit value, converts it to four BCD digits with a serial shift-add-3 engine,
// and scans the digits onto a common-anode 4-digit display with leading-zero blanking.
module bcd_display_driver #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input logic                clk,
    input logic                reset,
    bcd_display_driver_if.slave bus
);

    localparam int unsigned CntW = $clog2(REFRESH_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

    typedef enum logic [0:0] {StIdle, StConv} state_e;

    state_e          state_q, state_d;
    logic [25:0]     sr_q, sr_d, sr_adj;
    logic [3:0]      iter_q, iter_d;
    logic [15:0]     digits_q, digits_d;
    logic            done_q, done_d;
    logic [CntW-1:0] refresh_q, refresh_d;
    logic [1:0]      idx_q, idx_d;

    logic [3:0]      blank;
    logic [3:0]      sel_digit;
    logic [3:0]      an;
    logic [6:0]      seg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            sr_q      <= '0;
            iter_q    <= '0;
            digits_q  <= '0;
            done_q    <= 1'b0;
            refresh_q <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            iter_q    <= iter_d;
            digits_q  <= digits_d;
            done_q    <= done_d;
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
        end
    end

    // Add-3 correction on the four BCD nibbles that sit above the binary field.
    always_comb begin
        sr_adj = sr_q;
        for (int k = 0; k < 4; k++) begin
            if (sr_q[10+4*k +: 4] >= 4'd5) begin
                sr_adj[10+4*k +: 4] = sr_q[10+4*k +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        iter_d   = iter_q;
        digits_d = digits_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.load) begin
                    sr_d    = {16'b0, bus.q_in};
                    iter_d  = '0;
                    state_d = StConv;
                end
            end
            StConv: begin
                sr_d   = {sr_adj[24:0], 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd9) begin
                    digits_d = sr_d[25:10];
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        refresh_d = refresh_q + CntW'(1);
        idx_d     = idx_q;
        if (refresh_q == CntMax) begin
            refresh_d = '0;
            idx_d     = idx_q + 2'd1;
        end
    end

    // A digit is blanked only when it and every digit above it are zero.
    always_comb begin
        blank[3] = (digits_q[15:12] == 4'd0);
        blank[2] = blank[3] && (digits_q[11:8] == 4'd0);
        blank[1] = blank[2] && (digits_q[7:4] == 4'd0);
        blank[0] = 1'b0;
    end

    always_comb begin
        sel_digit = digits_q[4*idx_q +: 4];
        an        = 4'b1111;
        if (!blank[idx_q]) begin
            an[idx_q] = 1'b0;
        end
        case (sel_digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        if (blank[idx_q]) begin
            seg = 7'b1111111;
        end
    end

    assign bus.busy = (state_q == StConv);
    assign bus.done = done_q;
    assign bus.an   = an;
    assign bus.seg  = seg;
    assign bus.dp   = 1'b1;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed bench for bcd_display_driver: conversion timing, scanned digit patterns,
// leading-zero blanking, ignored loads during conversion and reset abort.
module tb_bcd_display_driver;

    localparam int unsigned Div = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bcd_display_driver_if bus ();

    bcd_display_driver #(
        .REFRESH_DIV (Div)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference scanner: slot index advances every Div clocks after reset.
    int unsigned m_cnt;
    logic [1:0]  m_idx;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt <= 0;
            m_idx <= 2'd0;
        end else if (m_cnt == Div - 1) begin
            m_cnt <= 0;
            m_idx <= m_idx + 2'd1;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    typedef struct {
        logic [9:0]       value;
        logic [3:0][6:0]  seg;  // indexed by slot
        logic [3:0][3:0]  an;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [9:0] v);
        @(negedge clk);
        bus.load = 1'b1;
        bus.q_in = v;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
    endtask

    // Call right after the load edge; checks 10 busy cycles and a single done 10 cycles later.
    task automatic conv_timing(input string name);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = -1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_at = i;
            end
        end
        check(busy_cnt == 10, {name, " busy cycles"}, busy_cnt, 10);
        check(done_cnt == 1, {name, " done pulses"}, done_cnt, 1);
        check(done_at == 10, {name, " done cycle"}, done_at, 10);
    endtask

    task automatic scan_check(input logic [3:0][6:0] es, input logic [3:0][3:0] ea,
                              input string name);
        for (int i = 0; i < 4 * Div; i++) begin
            @(negedge clk);
            check(bus.an == ea[m_idx] && bus.seg == es[m_idx],
                  $sformatf("%s slot%0d an/seg", name, m_idx),
                  {21'd0, bus.an, bus.seg}, {21'd0, ea[m_idx], es[m_idx]});
        end
        check(bus.dp == 1'b1, {name, " dp"}, bus.dp, 1);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        bus.load = 1'b0;
        bus.q_in = '0;

        vecs[0].value = 10'd5;
        vecs[0].seg   = {7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010};
        vecs[0].an    = {4'b1111, 4'b1111, 4'b1111, 4'b1110};
        vecs[1].value = 10'd1023;
        vecs[1].seg   = {7'b1111001, 7'b1000000, 7'b0100100, 7'b0110000};
        vecs[1].an    = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
        vecs[2].value = 10'd207;
        vecs[2].seg   = {7'b1111111, 7'b0100100, 7'b1000000, 7'b1111000};
        vecs[2].an    = {4'b1111, 4'b1011, 4'b1101, 4'b1110};
        vecs[3].value = 10'd0;
        vecs[3].seg   = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000};
        vecs[3].an    = {4'b1111, 4'b1111, 4'b1111, 4'b1110};
        vecs[4].value = 10'd40;
        vecs[4].seg   = {7'b1111111, 7'b1111111, 7'b0011001, 7'b1000000};
        vecs[4].an    = {4'b1111, 4'b1111, 4'b1101, 4'b1110};
        vecs[5].value = 10'd1000;
        vecs[5].seg   = {7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000};
        vecs[5].an    = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
        vecs[6].value = 10'd689;
        vecs[6].seg   = {7'b1111111, 7'b0000010, 7'b0000000, 7'b0010000};
        vecs[6].an    = {4'b1111, 4'b1011, 4'b1101, 4'b1110};

        #1;
        check(bus.an == 4'b1110, "reset an", bus.an, 4'b1110);
        check(bus.seg == 7'b1000000, "reset seg", bus.seg, 7'b1000000);
        check(bus.busy == 1'b0, "reset busy", bus.busy, 0);
        check(bus.done == 1'b0, "reset done", bus.done, 0);
        check(bus.dp == 1'b1, "reset dp", bus.dp, 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        foreach (vecs[k]) begin
            do_load(vecs[k].value);
            conv_timing($sformatf("load %0d", vecs[k].value));
            scan_check(vecs[k].seg, vecs[k].an, $sformatf("val %0d", vecs[k].value));
        end

        // Load 99, then a 512 load during busy cycle 4 must be ignored.
        begin
            int busy_cnt = 0;
            int done_cnt = 0;
            do_load(10'd99);
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (bus.busy) busy_cnt++;
                if (bus.done) done_cnt++;
                if (i == 3) begin
                    bus.load = 1'b1;
                    bus.q_in = 10'd512;
                end else begin
                    bus.load = 1'b0;
                end
            end
            check(busy_cnt == 10, "ignored load busy cycles", busy_cnt, 10);
            check(done_cnt == 1, "ignored load done pulses", done_cnt, 1);
            scan_check({7'b1111111, 7'b1111111, 7'b0010000, 7'b0010000},
                       {4'b1111, 4'b1111, 4'b1101, 4'b1110}, "val 99");
        end

        // Load 512 and reset during busy cycle 5: abort with no done and cleared digits.
        begin
            int done_cnt = 0;
            do_load(10'd512);
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (bus.done) done_cnt++;
            end
            #1;
            reset = 1'b1;
            #1;
            check(bus.an == 4'b1110, "abort an", bus.an, 4'b1110);
            check(bus.seg == 7'b1000000, "abort seg", bus.seg, 7'b1000000);
            check(bus.busy == 1'b0, "abort busy", bus.busy, 0);
            check(bus.done == 1'b0, "abort done", bus.done, 0);
            check(bus.dp == 1'b1, "abort dp", bus.dp, 1);
            @(negedge clk);
            reset = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.done) done_cnt++;
            end
            check(done_cnt == 0, "abort done pulses", done_cnt, 0);
            scan_check(vecs[3].seg, vecs[3].an, "after abort");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bcd_display_driver.md
# bcd_display_driver

Downstream consumer of the 10-bit registered result `Q` of `datapath`. It captures the value on a load strobe and converts it from unsigned binary to four BCD digits with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes those digits onto a 4-digit, common-anode seven-segment display, blanking leading zeros. It is the last stage before the board pins.

## Interface
- `REFRESH_DIV`, default 100000: clocks per digit slot; must be ≥ 2 (the bench uses 4).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `load`  in  1  capture `q_in` and start conversion; sampled on the rising edge.
- `q_in`  in  10  unsigned value to display, 0..1023; connects to `datapath.Q`.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse when new digits are committed.
- `an`  out  4  active-low digit enables; `an[0]` is the ones digit (rightmost).
- `seg`  out  7  active-low segments `{g,f,e,d,c,b,a}`.
- `dp`  out  1  decimal point, active-low; held at 1 (off).

## Operation
- FSM has two states, IDLE and CONV.
- **IDLE:**
  - When `load`=1, the block loads a 26-bit shift register: `{16'b0, q_in}`.
  - It clears the iteration count, enters CONV and asserts `busy`.
- **CONV, each clock:**
  - Every BCD nibble that is ≥5 gets +3.
  - The whole register then shifts left by 1.
  - The iteration count increments.
- **End of CONV:**
  - The 10th iteration writes the top 16 bits into the display digit registers `d3..d0`.
  - `done` pulses and the FSM returns to IDLE.
- `load` while `busy`=1 is ignored. It is neither queued nor used to restart the conversion.
- Display digits change only at commit. The previous value stays on the display during conversion.
- Range: `d3` ∈ {0,1}; `d2..d0` ∈ 0..9.
- **Scanner:**
  - A free-running counter counts 0..`REFRESH_DIV`-1.
  - On wrap, the 2-bit digit index advances 0→1→2→3→0.
- `an` is the one-hot-low decode of the index.
  - **Leading-zero blanking:** digit k (k ≥ 1) is blanked (`an` bit forced to 1) when `dk` and all higher digits are 0.
  - Digit 0 is never blanked.
- `seg` decodes the selected digit with these codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other value gives 1111111.
  - When the selected digit is blanked, `seg`=1111111.
- `an`, `seg` and `dp` are combinational decodes of registered state only (index and digits). `q_in` has no combinational path to them.

## Timing
- Reset values:
  - FSM=IDLE, `busy`=0, `done`=0.
  - Digits=0000, index=0, refresh counter=0.
  - `an`=1110, `seg`=1000000, `dp`=1.
- **Conversion latency**, with `load` sampled at edge N:
  - `busy`=1 after edge N.
  - Iterations run at edges N+1..N+10.
  - Digits update and `done`=1 after edge N+10.
  - `busy`=0 and `done`=0 after edge N+11.
  - A `load` at edge N+10 is ignored, because `busy` is still 1. A `load` at edge N+11 is accepted.
- `load` held high continuously restarts a conversion on every IDLE cycle, one every 11 clocks.
- Scan period is 4×`REFRESH_DIV` clocks. The index advances on the edge where the counter wraps from `REFRESH_DIV`-1 to 0.
- If a commit and an index change land on the same edge, both take effect and the new digits show in the new slot.
- Reset during CONV aborts the conversion. Digits return to 0 and no `done` pulse is produced.

## Test plan
- **Reset:** assert `reset` mid-run. Required immediately: `an`=1110, `seg`=1000000, `busy`=0, `done`=0, `dp`=1.
- **Load 10'd5:**
  - `busy` is high for exactly 10 cycles and `done` pulses once, 10 cycles after the load edge.
  - Over a full scan, only `an[0]` goes low, showing `seg`=0010010.
  - Slots 1–3 show `an`=1111.
- **Load 10'd1023** with `REFRESH_DIV`=4:
  - Digits are 1,0,2,3.
  - Slots 0..3 show 0110000, 0100100, 1000000, 1111001.
  - No slot is blanked.
- **Load 10'd207:**
  - Slot 1 shows 0 (`seg`=1000000), which is an internal zero and not blanked.
  - Slot 3 is blanked.
  - Slot 2 shows 0100100 and slot 0 shows 1111000.
- **Ignored and aborted loads:**
  - Load 10'd99, then pulse `load` with 10'd512 at cycle 4 of `busy`. The result must be 99 with a single `done` pulse.
  - Then load 512 and assert `reset` at cycle 5 of `busy`. Digits must be 0000 and `done` must never pulse.
